// File: rtl/vadd_pkg.sv
// ---------------------------------------------------------------------------
// vadd_pkg
// Shared constants and helpers for the float vector-add write path.
//   LANE_WIDTH      : width of one float lane in a packed word (32 bits)
//   LANE_KEEP_WIDTH : byte enables per lane
//   calc_ratio()    : lanes per wide word for a given narrow/wide width pair
// ---------------------------------------------------------------------------
package vadd_pkg;

    localparam int unsigned LANE_WIDTH      = 32;
    localparam int unsigned LANE_KEEP_WIDTH = LANE_WIDTH / 8;

    // Number of narrow beats that fit in one wide word. The narrow width
    // must divide the wide width exactly.
    function automatic int unsigned calc_ratio(input int unsigned m_width,
                                               input int unsigned s_width);
        return m_width / s_width;
    endfunction

endpackage

// File: rtl/vadd_axis_obuf.sv
// ---------------------------------------------------------------------------
// vadd_axis_obuf
// Single-entry AXI4-Stream output register. A load and a drain on the same
// edge leave the register full with the newly loaded word.
// Ports:
//   clk, areset          : clock, synchronous active-high reset
//   load                 : capture load_data/keep/last this edge
//   load_data/keep/last  : word to be registered
//   m_axis_tvalid/tready : downstream handshake
//   m_axis_tdata/tkeep/tlast : registered word
// The caller only asserts load when the register is empty or draining, so a
// held word is never overwritten.
// ---------------------------------------------------------------------------
module vadd_axis_obuf #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [KEEP_WIDTH-1:0] load_keep,
    input  logic                  load_last,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast
);

    logic                  obuf_valid_r;
    logic [DATA_WIDTH-1:0] obuf_data_r;
    logic [KEEP_WIDTH-1:0] obuf_keep_r;
    logic                  obuf_last_r;

    // Output register: load wins over a simultaneous drain.
    always_ff @(posedge clk) begin
        if (areset) begin
            obuf_valid_r <= 1'b0;
            obuf_data_r  <= {DATA_WIDTH{1'b0}};
            obuf_keep_r  <= {KEEP_WIDTH{1'b0}};
            obuf_last_r  <= 1'b0;
        end else if (load) begin
            obuf_valid_r <= 1'b1;
            obuf_data_r  <= load_data;
            obuf_keep_r  <= load_keep;
            obuf_last_r  <= load_last;
        end else if (obuf_valid_r && m_axis_tready) begin
            obuf_valid_r <= 1'b0;
        end else begin
            obuf_valid_r <= obuf_valid_r;
        end
    end

    assign m_axis_tvalid = obuf_valid_r;
    assign m_axis_tdata  = obuf_data_r;
    assign m_axis_tkeep  = obuf_keep_r;
    assign m_axis_tlast  = obuf_last_r;

endmodule

// File: rtl/vadd_float_packer.sv
// ---------------------------------------------------------------------------
// vadd_float_packer
// Packs the 32-bit float result stream of the vector adder into 512-bit
// words for the memory-write path. A word is emitted when all lanes are
// filled or when tlast arrives; partial words carry zero data and zero keep
// in unwritten lanes.
// Ports:
//   ap_aclk, ap_areset         : clock, synchronous active-high reset
//   s_axis_t{valid,ready,data,keep,last} : narrow float result stream
//   m_axis_t{valid,ready,data,keep,last} : wide packed stream, lane i at
//                                          bits [32i+31:32i]
// ---------------------------------------------------------------------------
module vadd_float_packer
    import vadd_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = LANE_WIDTH,
    parameter int C_M_AXIS_TDATA_WIDTH = 512
) (
    input  logic                              ap_aclk,
    input  logic                              ap_areset,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                              s_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                              m_axis_tlast
);

    localparam int LP_RATIO     = int'(calc_ratio(C_M_AXIS_TDATA_WIDTH, C_S_AXIS_TDATA_WIDTH));
    localparam int LP_CNT_WIDTH = $clog2(LP_RATIO);
    localparam int LP_S_KEEP    = C_S_AXIS_TDATA_WIDTH / 8;
    localparam int LP_M_KEEP    = C_M_AXIS_TDATA_WIDTH / 8;

    localparam logic [LP_CNT_WIDTH-1:0] LP_LAST_LANE = LP_CNT_WIDTH'(LP_RATIO - 1);
    localparam logic [LP_CNT_WIDTH-1:0] LP_LANE_ONE  = {{(LP_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LP_CNT_WIDTH-1:0] LP_LANE_ZERO = {LP_CNT_WIDTH{1'b0}};

    logic [LP_CNT_WIDTH-1:0]         lane_r;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] acc_data_r;
    logic [LP_M_KEEP-1:0]            acc_keep_r;

    logic [C_M_AXIS_TDATA_WIDTH-1:0] merged_data_s;
    logic [LP_M_KEEP-1:0]            merged_keep_s;
    logic                            s_tready_s;
    logic                            accept_s;
    logic                            complete_s;

    // Ready depends only on reset and the output register, never on tvalid.
    assign s_tready_s    = !ap_areset && (!m_axis_tvalid || m_axis_tready);
    assign s_axis_tready = s_tready_s;
    assign accept_s      = s_axis_tvalid && s_tready_s;
    // A null beat (tkeep==0) still occupies its lane and can complete a word.
    assign complete_s    = accept_s && ((lane_r == LP_LAST_LANE) || s_axis_tlast);

    // Assembly register with the incoming beat merged into the current lane.
    always_comb begin
        merged_data_s = acc_data_r;
        merged_keep_s = acc_keep_r;
        for (int i = 0; i < LP_RATIO; i++) begin
            if (lane_r == LP_CNT_WIDTH'(i)) begin
                merged_data_s[i*C_S_AXIS_TDATA_WIDTH +: C_S_AXIS_TDATA_WIDTH] = s_axis_tdata;
                merged_keep_s[i*LP_S_KEEP +: LP_S_KEEP]                       = s_axis_tkeep;
            end else begin
                merged_data_s[i*C_S_AXIS_TDATA_WIDTH +: C_S_AXIS_TDATA_WIDTH] =
                    acc_data_r[i*C_S_AXIS_TDATA_WIDTH +: C_S_AXIS_TDATA_WIDTH];
                merged_keep_s[i*LP_S_KEEP +: LP_S_KEEP] = acc_keep_r[i*LP_S_KEEP +: LP_S_KEEP];
            end
        end
    end

    // Lane counter and assembly register; cleared when a word is handed off
    // so the next word starts with zero data and keep in every lane.
    always_ff @(posedge ap_aclk) begin
        if (ap_areset) begin
            lane_r     <= LP_LANE_ZERO;
            acc_data_r <= {C_M_AXIS_TDATA_WIDTH{1'b0}};
            acc_keep_r <= {LP_M_KEEP{1'b0}};
        end else if (complete_s) begin
            lane_r     <= LP_LANE_ZERO;
            acc_data_r <= {C_M_AXIS_TDATA_WIDTH{1'b0}};
            acc_keep_r <= {LP_M_KEEP{1'b0}};
        end else if (accept_s) begin
            lane_r     <= lane_r + LP_LANE_ONE;
            acc_data_r <= merged_data_s;
            acc_keep_r <= merged_keep_s;
        end else begin
            lane_r     <= lane_r;
            acc_data_r <= acc_data_r;
            acc_keep_r <= acc_keep_r;
        end
    end

    vadd_axis_obuf #(
        .DATA_WIDTH (C_M_AXIS_TDATA_WIDTH),
        .KEEP_WIDTH (LP_M_KEEP)
    ) u_obuf (
        .clk           (ap_aclk),
        .areset        (ap_areset),
        .load          (complete_s),
        .load_data     (merged_data_s),
        .load_keep     (merged_keep_s),
        .load_last     (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast)
    );

endmodule
